// File: rtl/anc_tap_sequencer.sv
// Per-sample FIR tap walker for the ANC path: shifts the reference delay line, presents each
// tap to the LMS update stage, writes the returned weight back and accumulates y = sum(w*x).
module anc_tap_sequencer #(
  parameter int TAPS      = 16,
  parameter int ADAPT_LAT = 4
) (
  input  logic        Clk_100M,
  input  logic        Reset,
  input  logic        Sample_Valid,
  input  logic [10:0] Sample_In,
  input  logic [10:0] Err_In,
  input  logic        Adapt_En,
  output logic        FilterEN_Out,
  output logic [10:0] Sig_Out,
  output logic [10:0] Err_Out,
  output logic [10:0] Wz_Out,
  input  logic [10:0] Wz_Upd_In,
  output logic [10:0] Y_Out,
  output logic        Y_Valid,
  output logic        Busy,
  output logic        Overrun
);

  localparam int DATA_W = 11;
  localparam int PROD_W = 21;
  localparam int ACC_W  = 27;
  localparam int KW     = $clog2(TAPS);
  localparam int LW     = $clog2(ADAPT_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PRESENT,
    S_WB,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] x_q [TAPS];
  logic [DATA_W-1:0] w_q [TAPS];
  logic [DATA_W-1:0] samp_q, err_q, y_q;
  logic              adapt_q, ovr_q;
  logic [KW-1:0]     k_q;
  logic [LW-1:0]     lat_q;
  logic signed [ACC_W-1:0] acc_q;

  logic [DATA_W-1:0]        x_k, w_k;
  logic signed [DATA_W-1:0] xs, ws;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     k_last, lat_last, present;

  // Sign-magnitude to two's complement; -0 collapses to 0.
  function automatic logic signed [DATA_W-1:0] sm_to_tc(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] m;
    m = signed'({1'b0, v[DATA_W-2:0]});
    return v[DATA_W-1] ? -m : m;
  endfunction

  // Drop the Q0.10 weight scaling, clamp to +/-1023 and re-encode; zero is always +0.
  function automatic logic [DATA_W-1:0] sat_to_sm(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] n;
    s = a >>> 10;
    n = -s;
    if (s > 27'sd1023)       return 11'h3FF;
    else if (s < -27'sd1023) return 11'h7FF;
    else if (s < 27'sd0)     return {1'b1, n[DATA_W-2:0]};
    else                     return {1'b0, s[DATA_W-2:0]};
  endfunction

  assign x_k      = x_q[k_q];
  assign w_k      = w_q[k_q];
  assign xs       = sm_to_tc(x_k);
  assign ws       = sm_to_tc(w_k);
  assign prod     = PROD_W'(xs) * PROD_W'(ws);
  assign acc_d    = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign k_last   = (k_q == KW'(TAPS-1));
  assign lat_last = (lat_q == LW'(ADAPT_LAT-1));
  assign present  = (state_q == S_PRESENT);

  always_ff @(posedge Clk_100M) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Sample_Valid) state_d = S_SHIFT;
      S_SHIFT:   state_d = adapt_q ? S_PRESENT : S_WB;
      S_PRESENT: if (lat_last) state_d = S_WB;
      S_WB: begin
        if (k_last)       state_d = S_DONE;
        else if (adapt_q) state_d = S_PRESENT;
        else              state_d = S_WB;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      samp_q  <= '0;
      err_q   <= '0;
      adapt_q <= 1'b0;
      acc_q   <= '0;
      k_q     <= '0;
      lat_q   <= '0;
      y_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // A strobe is only accepted in IDLE; anything else (including DONE) is an overrun.
      if (Sample_Valid && (state_q != S_IDLE)) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (Sample_Valid) begin
            samp_q  <= Sample_In;
            err_q   <= Err_In;
            adapt_q <= Adapt_En;
          end
        end
        S_SHIFT: begin
          x_q[0] <= samp_q;
          for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
          acc_q <= '0;
          k_q   <= '0;
          lat_q <= '0;
        end
        S_PRESENT: begin
          lat_q <= lat_last ? '0 : lat_q + LW'(1);
        end
        S_WB: begin
          // acc uses the pre-update weight; the written-back weight only matters next frame.
          acc_q <= acc_d;
          if (adapt_q) w_q[k_q] <= Wz_Upd_In;
          if (k_last) y_q <= sat_to_sm(acc_d);
          else        k_q <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign FilterEN_Out = present;
  assign Sig_Out      = present ? x_k   : '0;
  assign Err_Out      = present ? err_q : '0;
  assign Wz_Out       = present ? w_k   : '0;
  assign Y_Out        = y_q;
  assign Y_Valid      = (state_q == S_DONE);
  assign Busy         = (state_q != S_IDLE);
  assign Overrun      = ovr_q;

endmodule

// File: tb/tb_anc_tap_sequencer.sv
// Randomized bench for anc_tap_sequencer with a frame-level reference model and an LMS update-stage stand-in.
module tb_anc_tap_sequencer;

  localparam int TAPS = 16;
  localparam int L    = 4;
  localparam int LAT_A = 2 + TAPS * (L + 1);
  localparam int LAT_N = 2 + TAPS;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Sample_Valid;
  logic [10:0] Sample_In, Err_In;
  logic        Adapt_En;
  logic        FilterEN_Out;
  logic [10:0] Sig_Out, Err_Out, Wz_Out;
  logic [10:0] Wz_Upd_In;
  logic [10:0] Y_Out;
  logic        Y_Valid, Busy, Overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] mx [TAPS];
  int          mw [TAPS];
  bit          movr;

  anc_tap_sequencer #(.TAPS(TAPS), .ADAPT_LAT(L)) dut (
    .Clk_100M     (clk),
    .Reset        (Reset),
    .Sample_Valid (Sample_Valid),
    .Sample_In    (Sample_In),
    .Err_In       (Err_In),
    .Adapt_En     (Adapt_En),
    .FilterEN_Out (FilterEN_Out),
    .Sig_Out      (Sig_Out),
    .Err_Out      (Err_Out),
    .Wz_Out       (Wz_Out),
    .Wz_Upd_In    (Wz_Upd_In),
    .Y_Out        (Y_Out),
    .Y_Valid      (Y_Valid),
    .Busy         (Busy),
    .Overrun      (Overrun)
  );

  always #5 clk = ~clk;

  function automatic int sm2i(input logic [10:0] v);
    return v[10] ? -int'(v[9:0]) : int'(v[9:0]);
  endfunction

  function automatic logic [10:0] i2sm(input int v);
    int          c;
    logic [9:0]  m;
    c = (v > 1023) ? 1023 : (v < -1023) ? -1023 : v;
    m = (c < 0) ? 10'(-c) : 10'(c);
    return {(c < 0), m};
  endfunction

  // LMS update stage stand-in: w + (x*e)>>7, sign-magnitude in and out.
  function automatic logic [10:0] upd_sm(input logic [10:0] x, input logic [10:0] e, input logic [10:0] w);
    return i2sm(sm2i(w) + ((sm2i(x) * sm2i(e)) >>> 7));
  endfunction

  always @(negedge clk) begin
    if (FilterEN_Out) Wz_Upd_In = upd_sm(Sig_Out, Err_Out, Wz_Out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_en"},   32'(FilterEN_Out), 0);
    chk({tag, "_sig"},  32'(Sig_Out), 0);
    chk({tag, "_err"},  32'(Err_Out), 0);
    chk({tag, "_wz"},   32'(Wz_Out), 0);
    chk({tag, "_y"},    32'(Y_Out), 0);
    chk({tag, "_yv"},   32'(Y_Valid), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_ovr"},  32'(Overrun), 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = '0;
      mw[i] = 0;
    end
    movr = 1'b0;
  endtask

  task automatic reset_dut();
    Reset = 1'b0;
    Sample_Valid = 1'b0;
    @(negedge clk);
    chk_zero_outputs("rst");
    Reset = 1'b1;
    model_clear();
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
  task automatic run_frame(input logic [10:0] s, input logic [10:0] e, input logic ad,
                           input int ovr_at, input int rst_at);
    int          lat, acc, y_at, en_hi, en_win, k, p;
    int          wpre [TAPS];
    logic [10:0] y_exp;
    logic        en_exp, prev_en, aborted;
    lat = ad ? LAT_A : LAT_N;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      wpre[i] = mw[i];
      acc += sm2i(mx[i]) * mw[i];
    end
    y_exp = i2sm(acc >>> 10);
    if (ad) for (int i = 0; i < TAPS; i++) mw[i] = sm2i(upd_sm(mx[i], e, i2sm(mw[i])));

    Sample_Valid = 1'b1;
    Sample_In = s;
    Err_In = e;
    Adapt_En = ad;
    y_at = -1; en_hi = 0; en_win = 0; prev_en = 1'b0; aborted = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      p = c - 2;
      en_exp = ad && (c >= 2) && (c < lat) && ((p % (L + 1)) < L);
      k = (c >= 2) ? p / (L + 1) : 0;
      chk("busy", 32'(Busy), 1);
      chk("y_valid", 32'(Y_Valid), 32'(c == lat));
      chk("filter_en", 32'(FilterEN_Out), 32'(en_exp));
      if (en_exp && k < TAPS) begin
        chk("sig_out", 32'(Sig_Out), 32'(mx[k]));
        chk("err_out", 32'(Err_Out), 32'(e));
        chk("wz_out",  32'(Wz_Out),  32'(i2sm(wpre[k])));
      end else begin
        chk("sig_idle", 32'(Sig_Out), 0);
        chk("err_idle", 32'(Err_Out), 0);
        chk("wz_idle",  32'(Wz_Out),  0);
      end
      if (FilterEN_Out && !prev_en) en_win++;
      if (FilterEN_Out) en_hi++;
      prev_en = FilterEN_Out;
      if (Y_Valid && y_at < 0) begin
        y_at = c;
        chk("y_out", 32'(Y_Out), 32'(y_exp));
        chk("y_not_neg0", 32'(Y_Out == 11'h400), 0);
      end
      Sample_Valid = (c == ovr_at);
      Sample_In = 11'($urandom);
      Err_In = 11'($urandom);
      Adapt_En = 1'($urandom);
      if (c == ovr_at) movr = 1'b1;
      if (c == rst_at) begin
        Reset = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    @(negedge clk);
    Sample_Valid = 1'b0;
    if (aborted) begin
      chk_zero_outputs("midrst");
      Reset = 1'b1;
      model_clear();
    end else begin
      chk("y_latency", 32'(y_at), 32'(lat));
      chk("en_windows", 32'(en_win), ad ? TAPS : 0);
      chk("en_cycles", 32'(en_hi), ad ? TAPS * L : 0);
      chk("busy_fall", 32'(Busy), 0);
      chk("y_pulse", 32'(Y_Valid), 0);
      chk("y_hold", 32'(Y_Out), 32'(y_exp));
      chk("overrun", 32'(Overrun), 32'(movr));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int ad, lat, ovr;
    Reset = 1'b0;
    Sample_Valid = 1'b0;
    Sample_In = '0;
    Err_In = '0;
    Adapt_En = 1'b0;
    Wz_Upd_In = '0;
    model_clear();

    // Reset held with random inputs.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero_outputs("por");
      Sample_Valid = 1'($urandom);
      Sample_In = 11'($urandom);
      Err_In = 11'($urandom);
      Adapt_En = 1'($urandom);
    end
    reset_dut();
    run_frame(11'd256, 11'($urandom), 1'b0, -1, -1);
    chk("first_y_zero", 32'(Y_Out), 0);

    // Adapt then filter, positive error.
    reset_dut();
    run_frame(11'd256, 11'd64, 1'b1, -1, -1);
    chk("adapt_y_zero", 32'(Y_Out), 0);
    run_frame(11'd256, 11'($urandom), 1'b0, -1, -1);
    chk("y_plus32", 32'(Y_Out), 32'h020);

    // Negative error path.
    reset_dut();
    run_frame(11'd256, 11'h440, 1'b1, -1, -1);
    run_frame(11'd256, 11'($urandom), 1'b0, -1, -1);
    chk("y_minus32", 32'(Y_Out), 32'h420);
    run_frame(11'd0, 11'($urandom), 1'b0, -1, -1);
    chk("y_zero_pos", 32'(Y_Out), 32'h000);

    // Overrun mid-frame, then sticky across the next frame.
    run_frame(11'($urandom), 11'($urandom), 1'b1, 40, -1);
    chk("ovr_sticky_set", 32'(Overrun), 1);
    run_frame(11'($urandom), 11'($urandom), 1'b0, -1, -1);
    chk("ovr_sticky_hold", 32'(Overrun), 1);

    // Overrun in the DONE cycle.
    reset_dut();
    run_frame(11'($urandom), 11'($urandom), 1'b0, LAT_N, -1);
    chk("ovr_done", 32'(Overrun), 1);

    // Mid-frame reset clears everything including partial weight updates.
    run_frame(11'd256, 11'd64, 1'b1, -1, -1);
    run_frame(11'($urandom), 11'($urandom), 1'b1, -1, 50);
    run_frame(11'd256, 11'($urandom), 1'b0, -1, -1);
    chk("post_rst_y", 32'(Y_Out), 0);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      ad  = int'($urandom_range(0, 1));
      lat = (ad != 0) ? LAT_A : LAT_N;
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : -1;
      run_frame(11'($urandom), 11'($urandom), 1'(ad), ovr, -1);
      repeat ($urandom_range(0, 2)) begin
        Sample_In = 11'($urandom);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
